// File: rtl/rv32_mem_pkg.sv
// rtl/rv32_mem_pkg.sv - funct3 load/store codes, FSM state type and access-size helper
package rv32_mem_pkg;

    localparam logic [2:0] MEM_B  = 3'b000;
    localparam logic [2:0] MEM_H  = 3'b001;
    localparam logic [2:0] MEM_W  = 3'b010;
    localparam logic [2:0] MEM_BU = 3'b100;
    localparam logic [2:0] MEM_HU = 3'b101;

    typedef enum logic {
        IDLE  = 1'b0,
        SPLIT = 1'b1
    } mem_state_t;

    // Access size in bytes; 0 marks an illegal funct3 code.
    function automatic logic [2:0] mem_size(input logic [2:0] funct3);
        case (funct3)
            MEM_B, MEM_BU: mem_size = 3'd1;
            MEM_H, MEM_HU: mem_size = 3'd2;
            MEM_W:         mem_size = 3'd4;
            default:       mem_size = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/data_lane_organizer.sv
// rtl/data_lane_organizer.sv - byte-lane steering for stores and byte selection/extension for loads
// Ports:
//   offset, funct3   byte offset within the word and access code
//   part             0 = low word of an access, 1 = high word of a split access
//   store_data       right-justified store data -> store_word/store_be for this part
//   lo_word/hi_word  the two words an access may span -> load_result (extended)
module data_lane_organizer
    import rv32_mem_pkg::*;
(
    input  logic [1:0]  offset,
    input  logic        part,
    input  logic [2:0]  funct3,
    input  logic [31:0] store_data,
    output logic [31:0] store_word,
    output logic [3:0]  store_be,
    input  logic [31:0] lo_word,
    input  logic [31:0] hi_word,
    output logic [31:0] load_result
);

    logic [3:0]  size_mask;
    logic [63:0] st_shift;
    logic [7:0]  be_shift;
    logic [63:0] ld_shift;
    logic [31:0] raw;

    always_comb begin
        case (mem_size(funct3))
            3'd1:    size_mask = 4'b0001;
            3'd2:    size_mask = 4'b0011;
            3'd4:    size_mask = 4'b1111;
            default: size_mask = 4'b0000;
        endcase

        // A 64-bit view of the two words lets one shift cover both halves
        // of a split access: the upper 32 bits are what spills into word+1.
        st_shift   = {32'b0, store_data} << {offset, 3'b000};
        be_shift   = {4'b0, size_mask} << offset;
        store_word = part ? st_shift[63:32] : st_shift[31:0];
        store_be   = part ? be_shift[7:4]   : be_shift[3:0];

        ld_shift = {hi_word, lo_word} >> {offset, 3'b000};
        raw      = ld_shift[31:0];
        case (funct3)
            MEM_B:   load_result = {{24{raw[7]}}, raw[7:0]};
            MEM_BU:  load_result = {24'b0, raw[7:0]};
            MEM_H:   load_result = {{16{raw[15]}}, raw[15:0]};
            MEM_HU:  load_result = {16'b0, raw[15:0]};
            MEM_W:   load_result = raw;
            default: load_result = 32'b0;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - byte-lane data RAM for the rv32i_core load/store port with misaligned split
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   req_i                 load/store request present this cycle
//   RAM_Addr_i            byte address (upper bits alias)
//   RAM_DATA_i            right-justified store data
//   RAM_DATA_control_i    funct3 size/sign code
//   RAM_rw_i              1 = store, 0 = load
//   MEM_result_o          extended load result, held until the next load completes
//   stall_o               high while the first half of a misaligned access is taken
//   err_o                 one-cycle pulse for an illegal funct3 code
module data_mem_responder
    import rv32_mem_pkg::*;
#(
    parameter int    DATA_WIDTH  = 32,
    parameter int    DEPTH_WORDS = 4096,
    parameter string INIT_FILE   = ""
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_i,
    input  logic [31:0]           RAM_Addr_i,
    input  logic [DATA_WIDTH-1:0] RAM_DATA_i,
    input  logic [2:0]            RAM_DATA_control_i,
    input  logic                  RAM_rw_i,
    output logic [DATA_WIDTH-1:0] MEM_result_o,
    output logic                  stall_o,
    output logic                  err_o
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] mem [DEPTH_WORDS];

    mem_state_t  state;
    logic [31:0] lo_buf;

    logic [AW-1:0] word_idx;
    logic [AW-1:0] access_idx;
    logic [1:0]    offset;
    logic [2:0]    size;
    logic          illegal;
    logic          misaligned;
    logic          in_split;
    logic [31:0]   rdata;
    logic [31:0]   store_word;
    logic [3:0]    store_be;
    logic [31:0]   load_result;
    logic          we;
    logic          unused_addr;

    assign unused_addr = ^RAM_Addr_i[31:AW+2];

    assign word_idx   = RAM_Addr_i[AW+1:2];
    assign offset     = RAM_Addr_i[1:0];
    assign size       = mem_size(RAM_DATA_control_i);
    assign illegal    = (size == 3'd0);
    assign misaligned = ((size == 3'd2) && (offset == 2'd3)) ||
                        ((size == 3'd4) && (offset != 2'd0));
    assign in_split   = (state == SPLIT);

    // The second half always targets the next word; the AW-bit add wraps
    // the top word back to word 0.
    assign access_idx = in_split ? word_idx + 1'b1 : word_idx;
    assign rdata      = mem[access_idx];

    assign stall_o = !reset && !in_split && req_i && !illegal && misaligned;

    // Gating with reset drops the high half of a store interrupted in SPLIT.
    assign we = !reset && req_i && RAM_rw_i && !illegal;

    data_lane_organizer u_lanes (
        .offset      (offset),
        .part        (in_split),
        .funct3      (RAM_DATA_control_i),
        .store_data  (RAM_DATA_i),
        .store_word  (store_word),
        .store_be    (store_be),
        .lo_word     (in_split ? lo_buf : rdata),
        .hi_word     (rdata),
        .load_result (load_result)
    );

    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < 4; i++) begin
                if (store_be[i]) begin
                    mem[access_idx][8*i +: 8] <= store_word[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            lo_buf       <= 32'b0;
            MEM_result_o <= '0;
            err_o        <= 1'b0;
        end else begin
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_i) begin
                        if (illegal) begin
                            MEM_result_o <= '0;
                            err_o        <= 1'b1;
                        end else if (misaligned) begin
                            state <= SPLIT;
                            if (!RAM_rw_i) begin
                                lo_buf <= rdata;
                            end
                        end else if (!RAM_rw_i) begin
                            MEM_result_o <= load_result;
                        end
                    end
                end
                SPLIT: begin
                    state <= IDLE;
                    if (req_i && !RAM_rw_i) begin
                        MEM_result_o <= load_result;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - directed self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [2:0]  f3;
    logic        rw;
    logic [31:0] result;
    logic        stall;
    logic        err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    data_mem_responder #(.DATA_WIDTH(32), .DEPTH_WORDS(16), .INIT_FILE("")) dut (
        .clk                (clk),
        .reset              (reset),
        .req_i              (req),
        .RAM_Addr_i         (addr),
        .RAM_DATA_i         (wdata),
        .RAM_DATA_control_i (f3),
        .RAM_rw_i           (rw),
        .MEM_result_o       (result),
        .stall_o            (stall),
        .err_o              (err)
    );

    task automatic put(input logic r, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] c, input logic w);
        req = r; addr = a; wdata = d; f3 = c; rw = w;
        #1;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        cyc(); cyc();
        total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=%h", result, 32'h0); end
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL reset_err got=%b exp=0", err); end
        reset = 1'b0;
    endtask

    task automatic test_word();
        put(1'b1, 32'h100, 32'hDEADBEEF, 3'b010, 1'b1);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_stall got=%b exp=0", stall); end
        cyc();
        put(1'b1, 32'h100, 32'h0, 3'b010, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL lw_stall got=%b exp=0", stall); end
        cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'hDEADBEEF) begin bad++; $display("FAIL lw_word got=%h exp=%h", result, 32'hDEADBEEF); end
    endtask

    task automatic test_extend();
        logic [31:0] addrs [4];
        logic [2:0]  codes [4];
        logic [31:0] exps  [4];
        addrs[0] = 32'h202; codes[0] = 3'b000; exps[0] = 32'hFFFFFFFF;
        addrs[1] = 32'h203; codes[1] = 3'b100; exps[1] = 32'h00000080;
        addrs[2] = 32'h200; codes[2] = 3'b001; exps[2] = 32'h00007F01;
        addrs[3] = 32'h202; codes[3] = 3'b101; exps[3] = 32'h000080FF;
        put(1'b1, 32'h200, 32'h80FF7F01, 3'b010, 1'b1);
        cyc();
        for (int i = 0; i < 4; i++) begin
            put(1'b1, addrs[i], 32'h0, codes[i], 1'b0);
            cyc();
            total++; if (result !== exps[i]) begin bad++; $display("FAIL extend_%0d got=%h exp=%h", i, result, exps[i]); end
        end
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    endtask

    task automatic test_partial_store();
        put(1'b1, 32'h300, 32'h11223344, 3'b010, 1'b1);
        cyc();
        put(1'b1, 32'h300, 32'h0, 3'b010, 1'b0);
        cyc();
        // upper data bits are junk and must not reach memory
        put(1'b1, 32'h301, 32'hFFFFFFAA, 3'b000, 1'b1);
        cyc();
        total++; if (result !== 32'h11223344) begin bad++; $display("FAIL store_holds_result got=%h exp=%h", result, 32'h11223344); end
        put(1'b1, 32'h300, 32'h0, 3'b010, 1'b0);
        cyc();
        total++; if (result !== 32'h1122AA44) begin bad++; $display("FAIL sb_merge got=%h exp=%h", result, 32'h1122AA44); end
        put(1'b1, 32'h302, 32'h1234BEEF, 3'b001, 1'b1);
        cyc();
        put(1'b1, 32'h300, 32'h0, 3'b010, 1'b0);
        cyc();
        total++; if (result !== 32'hBEEFAA44) begin bad++; $display("FAIL sh_merge got=%h exp=%h", result, 32'hBEEFAA44); end
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
    endtask

    task automatic test_misaligned();
        put(1'b1, 32'h400, 32'h0, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h404, 32'h0, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h401, 32'hCAFEBABE, 3'b010, 1'b1);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL msw_stall_first got=%b exp=1", stall); end
        cyc();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL msw_stall_second got=%b exp=0", stall); end
        cyc();
        put(1'b1, 32'h400, 32'h0, 3'b010, 1'b0); cyc();
        total++; if (result !== 32'hFEBABE00) begin bad++; $display("FAIL msw_lo_word got=%h exp=%h", result, 32'hFEBABE00); end
        put(1'b1, 32'h404, 32'h0, 3'b010, 1'b0); cyc();
        total++; if (result !== 32'h000000CA) begin bad++; $display("FAIL msw_hi_word got=%h exp=%h", result, 32'h000000CA); end
        put(1'b1, 32'h401, 32'h0, 3'b010, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL mlw_stall got=%b exp=1", stall); end
        cyc();
        total++; if (result !== 32'h000000CA) begin bad++; $display("FAIL mlw_hold_mid got=%h exp=%h", result, 32'h000000CA); end
        cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'hCAFEBABE) begin bad++; $display("FAIL mlw_result got=%h exp=%h", result, 32'hCAFEBABE); end
    endtask

    task automatic test_wrap();
        put(1'b1, 32'h3C, 32'h44332211, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h00, 32'h88776655, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h3E, 32'h0, 3'b010, 1'b0);
        cyc(); cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'h66554433) begin bad++; $display("FAIL wrap_lw got=%h exp=%h", result, 32'h66554433); end
        put(1'b1, 32'h3F, 32'h0, 3'b101, 1'b0);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL wrap_lhu_stall got=%b exp=1", stall); end
        cyc(); cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'h00005544) begin bad++; $display("FAIL wrap_lhu got=%h exp=%h", result, 32'h00005544); end
    endtask

    task automatic test_illegal();
        put(1'b1, 32'h10, 32'h12345678, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h10, 32'h0, 3'b010, 1'b0); cyc();
        put(1'b1, 32'h10, 32'hFFFFFFFF, 3'b011, 1'b1);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL illegal_stall got=%b exp=0", stall); end
        cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (err !== 1'b1) begin bad++; $display("FAIL illegal_err got=%b exp=1", err); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL illegal_result got=%h exp=0", result); end
        cyc();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL illegal_err_pulse got=%b exp=0", err); end
        put(1'b1, 32'h10, 32'h0, 3'b010, 1'b0); cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'h12345678) begin bad++; $display("FAIL illegal_nowrite got=%h exp=%h", result, 32'h12345678); end
    endtask

    task automatic test_reset_split();
        put(1'b1, 32'h4, 32'h0, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h8, 32'h11111111, 3'b010, 1'b1); cyc();
        put(1'b1, 32'h8, 32'h0, 3'b010, 1'b0); cyc();
        put(1'b1, 32'h5, 32'hA1B2C3D4, 3'b010, 1'b1);
        total++; if (stall !== 1'b1) begin bad++; $display("FAIL rsplit_stall got=%b exp=1", stall); end
        cyc();
        reset = 1'b1;
        cyc();
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rsplit_stall_after got=%b exp=0", stall); end
        total++; if (result !== 32'h0) begin bad++; $display("FAIL rsplit_result got=%h exp=0", result); end
        reset = 1'b0;
        put(1'b1, 32'h4, 32'h0, 3'b010, 1'b0);
        total++; if (stall !== 1'b0) begin bad++; $display("FAIL rsplit_idle got=%b exp=0", stall); end
        cyc();
        total++; if (result !== 32'hB2C3D400) begin bad++; $display("FAIL rsplit_lo_kept got=%h exp=%h", result, 32'hB2C3D400); end
        put(1'b1, 32'h8, 32'h0, 3'b010, 1'b0); cyc();
        put(1'b0, 32'h0, 32'h0, 3'b010, 1'b0);
        total++; if (result !== 32'h11111111) begin bad++; $display("FAIL rsplit_hi_dropped got=%h exp=%h", result, 32'h11111111); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_word();
        test_extend();
        test_partial_store();
        test_misaligned();
        test_wrap();
        test_illegal();
        test_reset_split();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
